// File: rtl/i2c_master_controller_if.sv
// Command/status handshake and I2C pin bundle for i2c_master_controller.
// The master modport is the controller's view; slave is the driving side.
interface i2c_master_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] mem_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ack_error;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        input  start, rw, dev_addr, mem_addr, wdata, sda_i,
        output busy, done, rdata, ack_error, scl_o, sda_oe
    );

    modport slave (
        output start, rw, dev_addr, mem_addr, wdata, sda_i,
        input  busy, done, rdata, ack_error, scl_o, sda_oe
    );
endinterface

// File: rtl/i2c_master_controller.sv
// Single-transaction I2C master: START, dev+R/W, ACK, mem addr, ACK, data, ACK, STOP.
// Optional macro I2C_MASTER_ACK_CHECK_EN enables NACK detection with early STOP.
module i2c_master_controller #(
    parameter int CLK_QUARTER = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    i2c_master_controller_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV, S_ACK1, S_MADDR, S_ACK2, S_DATA, S_ACK3, S_STOP
    } state_t;

    localparam logic [7:0] QUARTER_LAST = 8'(CLK_QUARTER - 1);

    state_t     r_state;
    logic [7:0] r_sub;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic       r_rw;
    logic [6:0] r_dev_addr;
    logic [7:0] r_mem_addr;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rdata;
    logic       r_ack_error;
    logic       r_scl;
    logic       r_sda_oe;

    state_t     w_state_next;
    logic [7:0] w_sub_next;
    logic [1:0] w_q_next;
    logic [2:0] w_bit_next;
    logic       w_q_end;
    logic       w_bit_end;
    logic       w_sample;
    logic       w_nack;
    logic [7:0] w_tx_byte;
    logic       w_scl_next;
    logic       w_sda_oe_next;

`ifdef I2C_MASTER_ACK_CHECK_EN
    assign w_nack = r_ack_error;
`else
    assign w_nack = 1'b0;
`endif

    // Position (state, bit, quarter, sub-cycle) of the next cycle.
    always_comb begin
        w_q_end      = (r_sub == QUARTER_LAST);
        w_bit_end    = w_q_end && (r_q == 2'd3);
        w_sample     = w_q_end && (r_q == 2'd2);
        w_state_next = r_state;
        w_sub_next   = w_q_end ? 8'd0 : r_sub + 8'd1;
        w_q_next     = w_q_end ? r_q + 2'd1 : r_q;
        w_bit_next   = r_bit;
        if (r_state == S_IDLE) begin
            w_sub_next = 8'd0;
            w_q_next   = 2'd0;
            w_bit_next = 3'd0;
            if (bus.start) begin
                w_state_next = S_START;
            end
        end else if (w_bit_end) begin
            w_bit_next = 3'd0;
            case (r_state)
                S_START: w_state_next = S_DEV;
                S_DEV: begin
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = S_ACK1;
                end
                S_ACK1:  w_state_next = w_nack ? S_STOP : S_MADDR;
                S_MADDR: begin
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = S_ACK2;
                end
                S_ACK2:  w_state_next = w_nack ? S_STOP : S_DATA;
                S_DATA: begin
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = S_ACK3;
                end
                S_ACK3:  w_state_next = S_STOP;
                S_STOP:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Pin levels are derived from the next position so they can be registered.
    always_comb begin
        w_tx_byte = 8'h00;
        case (w_state_next)
            S_DEV:   w_tx_byte = {r_dev_addr, r_rw};
            S_MADDR: w_tx_byte = r_mem_addr;
            S_DATA:  w_tx_byte = r_wdata;
            default: w_tx_byte = 8'h00;
        endcase
        w_scl_next    = w_q_next[1];
        w_sda_oe_next = 1'b0;
        case (w_state_next)
            S_IDLE:  w_scl_next = 1'b1;
            S_START: begin
                w_scl_next    = 1'b1;
                w_sda_oe_next = w_q_next[1];
            end
            S_DEV, S_MADDR: w_sda_oe_next = ~w_tx_byte[3'd7 - w_bit_next];
            S_DATA:  w_sda_oe_next = r_rw ? 1'b0 : ~w_tx_byte[3'd7 - w_bit_next];
            S_ACK3:  w_sda_oe_next = r_rw;
            S_STOP: begin
                w_scl_next    = (w_q_next != 2'd0);
                w_sda_oe_next = (w_q_next != 2'd3);
            end
            default: w_sda_oe_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sub       <= 8'd0;
            r_q         <= 2'd0;
            r_bit       <= 3'd0;
            r_rw        <= 1'b0;
            r_dev_addr  <= 7'd0;
            r_mem_addr  <= 8'd0;
            r_wdata     <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= 8'd0;
            r_ack_error <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sub    <= w_sub_next;
            r_q      <= w_q_next;
            r_bit    <= w_bit_next;
            r_scl    <= w_scl_next;
            r_sda_oe <= w_sda_oe_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= (r_state == S_STOP) && (w_state_next == S_IDLE);
            if (r_state == S_IDLE && bus.start) begin
                r_rw        <= bus.rw;
                r_dev_addr  <= bus.dev_addr;
                r_mem_addr  <= bus.mem_addr;
                r_wdata     <= bus.wdata;
                r_rdata     <= 8'd0;
                r_ack_error <= 1'b0;
            end
            if (w_sample && r_state == S_DATA && r_rw) begin
                r_rdata <= {r_rdata[6:0], bus.sda_i};
            end
`ifdef I2C_MASTER_ACK_CHECK_EN
            // A released SDA at an ACK sample point is a NACK; write ACK3 only.
            if (w_sample && bus.sda_i &&
                (r_state == S_ACK1 || r_state == S_ACK2 || (r_state == S_ACK3 && !r_rw))) begin
                r_ack_error <= 1'b1;
            end
`endif
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.ack_error = r_ack_error;
    assign bus.scl_o     = r_scl;
    assign bus.sda_oe    = r_sda_oe;
endmodule

// File: tb/tb_i2c_master_controller.sv
// Self-checking bench for i2c_master_controller: slot-level bus model plus slave memory,
// compared every cycle, with directed literal checks on latency, bit stream and status.
`timescale 1ns/1ps
module tb_i2c_master_controller;
    localparam int CQ  = 2;
    localparam int PER = 4 * CQ;
`ifdef I2C_MASTER_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_master_controller_if bus();
    i2c_master_controller #(.CLK_QUARTER(CQ)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic slave_pull = 1'b0;
    assign bus.sda_i = ~(bus.sda_oe | slave_pull);

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Behavioural model: a transaction is a list of bit-period slots.
    bit         chk_en = 1'b0;
    bit         tx_nack = 1'b0;
    bit         m_active = 1'b0;
    bit         m_done_now = 1'b0;
    bit         m_nack = 1'b0;
    int         m_k = 0;
    int         m_nslots = 29;
    logic       m_rw = 1'b0;
    logic [6:0] m_dev = '0;
    logic [7:0] m_mem = '0, m_wd = '0, m_rbyte = '0, m_rdata = '0;
    logic       m_ackerr = 1'b0;
    logic [7:0] slave_mem [0:255];
    int         s, q, n;
    logic [1:0] eb;
    logic [12:0] expv;

    function automatic logic [1:0] exp_bus(input int si, input int qi);
        logic [7:0] b;
        logic       scl;
        scl = (qi >= 2);
        if (si == 0) return {1'b1, scl};
        if (si == m_nslots - 1) return {(qi != 0), (qi != 3)};
        if (si >= 1 && si <= 8) begin
            b = {m_dev, m_rw};
            return {scl, ~b[8 - si]};
        end
        if (si >= 10 && si <= 17) begin
            b = m_mem;
            return {scl, ~b[17 - si]};
        end
        if (si >= 19 && si <= 26) begin
            b = m_wd;
            return {scl, m_rw ? 1'b0 : ~b[26 - si]};
        end
        if (si == 27) return {scl, m_rw};
        return {scl, 1'b0};
    endfunction

    function automatic logic slave_drive(input int si);
        if (si == 9) return !m_nack;
        if (si == 18) return 1'b1;
        if (si == 27) return !m_rw;
        if (m_rw && si >= 19 && si <= 26) return ~m_rbyte[26 - si];
        return 1'b0;
    endfunction

    always begin
        @(posedge clk);
        m_done_now = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_rdata  = 8'h00;
            m_ackerr = 1'b0;
        end else if (m_active) begin
            m_k++;
            if (m_k == m_nslots * PER) begin
                m_active   = 1'b0;
                m_done_now = 1'b1;
                if (!m_rw && !m_nack) slave_mem[m_mem] = m_wd;
            end
        end else if (bus.start) begin
            m_active = 1'b1;
            m_k      = 0;
            m_rw     = bus.rw;
            m_dev    = bus.dev_addr;
            m_mem    = bus.mem_addr;
            m_wd     = bus.wdata;
            m_nack   = tx_nack;
            m_rbyte  = slave_mem[bus.mem_addr];
            m_nslots = (ACK_CHECK && tx_nack) ? 11 : 29;
            m_rdata  = 8'h00;
            m_ackerr = 1'b0;
        end
        @(negedge clk);
        if (m_active) begin
            s  = m_k / PER;
            q  = (m_k % PER) / CQ;
            eb = exp_bus(s, q);
            if (m_rw) begin
                n = (s < 19) ? 0 : (s > 26) ? 8 : (s - 19 + ((q == 3) ? 1 : 0));
                m_rdata = (n == 0) ? 8'h00 : (m_rbyte >> (8 - n));
            end
            if (ACK_CHECK && m_nack && (s > 9 || (s == 9 && q == 3))) m_ackerr = 1'b1;
            slave_pull = slave_drive(s);
            expv = {1'b1, 1'b0, eb, m_ackerr, m_rdata};
        end else begin
            slave_pull = 1'b0;
            expv = {1'b0, m_done_now, 2'b10, m_ackerr, m_rdata};
        end
        if (chk_en)
            chk("cycle", 32'({bus.busy, bus.done, bus.scl_o, bus.sda_oe, bus.ack_error, bus.rdata}),
                32'(expv));
    end

    // Bus observer: bit on SDA at every SCL rising edge, and done pulse count.
    logic        prev_scl = 1'b1;
    logic [31:0] stream = '0;
    int          nrise = 0;
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (bus.scl_o && !prev_scl) begin
            stream = {stream[30:0], ~(bus.sda_oe | slave_pull)};
            nrise++;
        end
        prev_scl = bus.scl_o;
        if (bus.done) done_cnt++;
    end

    task automatic launch(input logic rw, input logic [6:0] dev, input logic [7:0] mem,
                          input logic [7:0] wd, input bit nack);
        bus.rw = rw; bus.dev_addr = dev; bus.mem_addr = mem; bus.wdata = wd;
        tx_nack = nack;
        bus.start = 1'b1;
        stream = '0;
        nrise = 0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int n0);
        int cnt;
        cnt = n0;
        while (!bus.done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk(name, 32'(cnt), 32'(exp_lat));
    endtask

    int dc0;
    initial begin
        bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = '0; bus.mem_addr = '0; bus.wdata = '0;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_state",
            32'({bus.busy, bus.done, bus.scl_o, bus.sda_oe, bus.ack_error, bus.rdata}),
            32'(13'b0_0_1_0_0_00000000));
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Write dev=1 mem=0x01 data=0x7F
        launch(1'b0, 7'd1, 8'h01, 8'h7F, 1'b0);
        wait_done("t1_latency", 233, 1);
        chk("t1_rises", 32'(nrise), 32'd28);
        chk("t1_bits", 32'(stream[27:0]), 32'(28'b0000001_0_0_00000001_0_01111111_0_0));
        chk("t1_ack_error", 32'(bus.ack_error), 32'd0);
        @(negedge clk);

        // Read dev=1 mem=0x01, slave returns 0x05
        slave_mem[1] = 8'h05;
        launch(1'b1, 7'd1, 8'h01, 8'h00, 1'b0);
        wait_done("t2_latency", 233, 1);
        chk("t2_rdata", 32'(bus.rdata), 32'h05);
        chk("t2_data_bits", 32'(stream[9:2]), 32'h05);
        chk("t2_master_ack", 32'(stream[1]), 32'd0);
        @(negedge clk);

        // Write 0x7F to mem 2, then read it back with start in the done cycle
        launch(1'b0, 7'd1, 8'h02, 8'h7F, 1'b0);
        wait_done("t3_latency", 233, 1);
        launch(1'b1, 7'd1, 8'h02, 8'h00, 1'b0);
        wait_done("t4_latency", 233, 1);
        chk("t4_rdata", 32'(bus.rdata), 32'h7F);
        @(negedge clk);

        // Start pulsed at T+40 while busy must be ignored
        dc0 = done_cnt;
        launch(1'b0, 7'h55, 8'h03, 8'hA5, 1'b0);
        repeat (39) @(negedge clk);
        bus.rw = 1'b1; bus.dev_addr = 7'h2A; bus.mem_addr = 8'h44; bus.wdata = 8'h5A;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t5_latency", 233, 41);
        chk("t5_bits", 32'(stream[27:0]), 32'(28'b1010101_0_0_00000011_0_10100101_0_0));
        repeat (20) @(negedge clk);
        chk("t5_single_done", 32'(done_cnt - dc0), 32'd1);

        // Slave NACKs the device address
        launch(1'b0, 7'h22, 8'h04, 8'h11, 1'b1);
        wait_done("t6_latency", ACK_CHECK ? 89 : 233, 1);
        chk("t6_ack_error", 32'(bus.ack_error), ACK_CHECK ? 32'd1 : 32'd0);
        repeat (10) @(negedge clk);
        chk("t6_ack_error_held", 32'(bus.ack_error), ACK_CHECK ? 32'd1 : 32'd0);

        // Reset at T+50 aborts the transaction without a STOP
        launch(1'b1, 7'd1, 8'h01, 8'h00, 1'b0);
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t7_reset_bus",
            32'({bus.busy, bus.done, bus.scl_o, bus.sda_oe, bus.rdata}),
            32'(12'b0_0_1_0_00000000));
        dc0 = done_cnt;
        repeat (300) @(negedge clk);
        chk("t7_no_done", 32'(done_cnt - dc0), 32'd0);

        // Recovery after reset
        launch(1'b0, 7'd1, 8'h05, 8'h3C, 1'b0);
        wait_done("t8_latency", 233, 1);
        chk("t8_ack_error", 32'(bus.ack_error), 32'd0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
